// File: rtl/efpga_tcdm_pkg.sv
// Shared types for the eFPGA TCDM arbiter: request/response bundles, port ID, default address base.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package efpga_tcdm_pkg;

  // Widest eFPGA-side address the request bundle can carry; the arbiter's ADDR_W must not exceed it.
  localparam int TCDM_ADDR_W = 20;
  // Enough bits to name up to 8 eFPGA ports.
  localparam int PORT_ID_W = 3;
  // Upper address bits prepended to eFPGA addresses by default (L2 window).
  localparam logic [31:0] ADDR_BASE_DEF = 32'h1C00_0000;

  typedef logic [PORT_ID_W-1:0] port_id_t;

  typedef struct packed {
    logic                   wen;   // 1 = read, 0 = write
    logic [TCDM_ADDR_W-1:0] addr;
    logic [3:0]             be;
    logic [31:0]            wdata;
  } tcdm_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
  } tcdm_rsp_t;

endpackage

// File: rtl/efpga_tcdm_id_fifo.sv
// Small FIFO of port IDs for in-order response routing.
// Latency: head visible the cycle after push into an empty FIFO; push and pop may share a cycle.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full_o/empty_o.
// Ports: clk_i/rst_ni (async active-low), push_i/din_i, pop_i, head_o, full_o, empty_o.
module efpga_tcdm_id_fifo #(
  parameter int DEPTH = 4,   // power of 2
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage needs no reset: the head is only consumed while count_q is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/efpga_tcdm_arbiter.sv
// Round-robin arbiter folding N_PORTS eFPGA TCDM masters onto one SoC interconnect port.
// Latency: request select and grant are combinational (0 cycles); responses routed the same cycle as m_rvalid_i.
// Backpressure: m_req_o drops while MAX_OUTST responses are pending; requesters hold req/payload until granted.
// Ports: s_* per-port slave side (req/wen/addr/be/wdata in, gnt/rvalid/rdata out), m_* interconnect side,
//   err_o sticky unexpected-response flag, stat_clr_i/stat_cnt_o per-port grant counters.
// Build option: define EFPGA_TCDM_ARB_STATS_EN for 16-bit saturating grant counters; otherwise stat_cnt_o is 0.
module efpga_tcdm_arbiter
  import efpga_tcdm_pkg::*;
#(
  parameter int          N_PORTS   = 4,
  parameter int          ADDR_W    = TCDM_ADDR_W,
  parameter int          MAX_OUTST = 4,
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_PORTS-1:0]    s_req_i,
  input  logic [N_PORTS-1:0]    s_wen_i,
  input  logic [N_PORTS*ADDR_W-1:0] s_addr_i,
  input  logic [N_PORTS*4-1:0]  s_be_i,
  input  logic [N_PORTS*32-1:0] s_wdata_i,
  output logic [N_PORTS-1:0]    s_gnt_o,
  output logic [N_PORTS-1:0]    s_rvalid_o,
  output logic [N_PORTS*32-1:0] s_rdata_o,
  output logic                  m_req_o,
  output logic                  m_wen_o,
  output logic [31:0]           m_addr_o,
  output logic [3:0]            m_be_o,
  output logic [31:0]           m_wdata_o,
  input  logic                  m_gnt_i,
  input  logic                  m_rvalid_i,
  input  logic [31:0]           m_rdata_i,
  output logic                  err_o,
  input  logic                  stat_clr_i,
  output logic [N_PORTS*16-1:0] stat_cnt_o
);

  tcdm_req_t port_req [N_PORTS];
  tcdm_req_t sel_req;
  tcdm_rsp_t m_rsp;
  port_id_t  rr_ptr_q, sel, sel_hi, sel_lo, fifo_head;
  logic      found_hi, fifo_full, fifo_empty, push, pop;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      port_req[i].wen   = s_wen_i[i];
      port_req[i].addr  = TCDM_ADDR_W'(s_addr_i[i*ADDR_W +: ADDR_W]);
      port_req[i].be    = s_be_i[i*4 +: 4];
      port_req[i].wdata = s_wdata_i[i*32 +: 32];
    end
  end

  assign m_rsp = '{rvalid: m_rvalid_i, rdata: m_rdata_i};

  // Round robin as two priority scans: lowest requester at or above the pointer,
  // falling back to the lowest requester overall (the wrapped part of the search).
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (s_req_i[i]) begin
        sel_lo = port_id_t'(i);
        if (port_id_t'(i) >= rr_ptr_q) begin
          sel_hi   = port_id_t'(i);
          found_hi = 1'b1;
        end
      end
    end
    sel = found_hi ? sel_hi : sel_lo;
  end

  // A full ID FIFO blocks the request even if a pop frees a slot this cycle.
  assign m_req_o = (|s_req_i) && !fifo_full;
  assign push    = m_req_o && m_gnt_i;
  assign pop     = m_rsp.rvalid && !fifo_empty;

  always_comb begin
    sel_req    = '0;
    s_gnt_o    = '0;
    s_rvalid_o = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (m_req_o && (sel == port_id_t'(i))) sel_req = port_req[i];
      if (push && (sel == port_id_t'(i)))    s_gnt_o[i] = 1'b1;
      if (pop && (fifo_head == port_id_t'(i))) s_rvalid_o[i] = 1'b1;
    end
  end

  assign m_wen_o   = sel_req.wen;
  assign m_addr_o  = m_req_o ? {ADDR_BASE[31:ADDR_W], sel_req.addr[ADDR_W-1:0]} : '0;
  assign m_be_o    = sel_req.be;
  assign m_wdata_o = sel_req.wdata;
  assign s_rdata_o = {N_PORTS{m_rsp.rdata}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      err_o    <= 1'b0;
    end else begin
      if (push) rr_ptr_q <= (sel == port_id_t'(N_PORTS - 1)) ? '0 : sel + 1'b1;
      // A response with nothing outstanding has no owner; flag it until reset.
      if (m_rsp.rvalid && fifo_empty) err_o <= 1'b1;
    end
  end

  efpga_tcdm_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (PORT_ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .din_i   (sel),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef EFPGA_TCDM_ARB_STATS_EN
  logic [15:0] cnt_q [N_PORTS];

  // Clear has priority over a same-cycle grant; counters stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (stat_clr_i)                             cnt_q[i] <= '0;
        else if (s_gnt_o[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_cnt_o = '0;
    for (int i = 0; i < N_PORTS; i++) stat_cnt_o[i*16 +: 16] = cnt_q[i];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_efpga_tcdm_arbiter.sv
// Directed bench for efpga_tcdm_arbiter with a queue-based scoreboard.
// Stimulus pushes expected grants/responses; a negedge monitor pops and compares on each handshake/rvalid.
// Also checks reset state, full blocking, grant hold, error flag and (when enabled) grant counters.
module tb_efpga_tcdm_arbiter;

  localparam int N  = 4;
  localparam int AW = 20;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    s_req_i, s_wen_i;
  logic [N*AW-1:0] s_addr_i;
  logic [N*4-1:0]  s_be_i;
  logic [N*32-1:0] s_wdata_i;
  logic [N-1:0]    s_gnt_o, s_rvalid_o;
  logic [N*32-1:0] s_rdata_o;
  logic            m_req_o, m_wen_o;
  logic [31:0]     m_addr_o, m_wdata_o;
  logic [3:0]      m_be_o;
  logic            m_gnt_i, m_rvalid_i;
  logic [31:0]     m_rdata_i;
  logic            err_o, stat_clr_i;
  logic [N*16-1:0] stat_cnt_o;

  efpga_tcdm_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_req_i(s_req_i), .s_wen_i(s_wen_i), .s_addr_i(s_addr_i), .s_be_i(s_be_i), .s_wdata_i(s_wdata_i),
    .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
    .m_req_o(m_req_o), .m_wen_o(m_wen_o), .m_addr_o(m_addr_o), .m_be_o(m_be_o), .m_wdata_o(m_wdata_o),
    .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .err_o(err_o), .stat_clr_i(stat_clr_i), .stat_cnt_o(stat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_gnt_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
  } exp_rsp_t;

  exp_gnt_t exp_gnt [$];
  exp_rsp_t exp_rsp [$];

  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b1;

  logic        pay_wen   [N];
  logic [19:0] pay_addr  [N];
  logic [3:0]  pay_be    [N];
  logic [31:0] pay_wdata [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_port(input int p, input logic wen, input logic [19:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
    pay_wen[p] = wen; pay_addr[p] = addr; pay_be[p] = be; pay_wdata[p] = wdata;
    s_wen_i[p]           = wen;
    s_addr_i[p*AW +: AW] = addr;
    s_be_i[p*4 +: 4]     = be;
    s_wdata_i[p*32 +: 32] = wdata;
  endtask

  // Expected grant built from the payload the bench drove; base 0x1C0 is the fixed upper address.
  task automatic want_gnt(input int p);
    exp_gnt.push_back('{port: p, addr: {12'h1C0, pay_addr[p]}, wen: pay_wen[p],
                        be: pay_be[p], wdata: pay_wdata[p]});
  endtask

  task automatic want_rsp(input int p, input logic [31:0] d);
    exp_rsp.push_back('{port: p, rdata: d});
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    exp_gnt_t eg;
    exp_rsp_t er;
    if (rst_ni && mon_en) begin
      if (m_req_o && m_gnt_i) begin
        if (exp_gnt.size() == 0) begin
          chk("gnt_unexpected", 64'(s_gnt_o), 64'd0);
        end else begin
          eg = exp_gnt.pop_front();
          chk("gnt_port",  64'(s_gnt_o),   64'd1 << eg.port);
          chk("gnt_addr",  64'(m_addr_o),  64'(eg.addr));
          chk("gnt_wen",   64'(m_wen_o),   64'(eg.wen));
          chk("gnt_be",    64'(m_be_o),    64'(eg.be));
          chk("gnt_wdata", 64'(m_wdata_o), 64'(eg.wdata));
        end
      end else if (|s_req_i) begin
        chk("gnt_idle", 64'(s_gnt_o), 64'd0);
      end
      if (m_rvalid_i) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 64'(s_rvalid_o), 64'd0);
        end else begin
          er = exp_rsp.pop_front();
          chk("rsp_port",  64'(s_rvalid_o), 64'd1 << er.port);
          chk("rsp_rdata", 64'(s_rdata_o[er.port*32 +: 32]), 64'(er.rdata));
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    s_req_i = '0; s_wen_i = '0; s_addr_i = '0; s_be_i = '0; s_wdata_i = '0;
    m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0; stat_clr_i = 1'b0;
    for (int p = 0; p < N; p++)
      set_port(p, (p % 2) == 0, 20'h01000 + 20'(p * 16), 4'(p + 1), 32'hA000_0000 + 32'(p));

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_m_req",  64'(m_req_o),    64'd0);
    chk("rst_m_addr", 64'(m_addr_o),   64'd0);
    chk("rst_gnt",    64'(s_gnt_o),    64'd0);
    chk("rst_rvalid", 64'(s_rvalid_o), 64'd0);
    chk("rst_err",    64'(err_o),      64'd0);
    chk("rst_stat",   64'(stat_cnt_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // 1: all ports request, back-to-back grants, responses one cycle later
    for (int c = 0; c < 8; c++) want_gnt(c % 4);
    for (int c = 1; c <= 8; c++) want_rsp((c - 1) % 4, 32'h5000_0000 + 32'(c));
    for (int c = 0; c <= 8; c++) begin
      s_req_i    = (c < 8) ? 4'hF : 4'h0;
      m_gnt_i    = 1'b1;
      m_rvalid_i = (c >= 1);
      m_rdata_i  = 32'h5000_0000 + 32'(c);
      tick();
    end
    m_rvalid_i = 1'b0; m_gnt_i = 1'b0;
`ifndef EFPGA_TCDM_ARB_STATS_EN
    stat_clr_i = 1'b1;
    @(negedge clk_i);
    chk("stat_tied_zero", 64'(stat_cnt_o), 64'd0);
    tick();
    stat_clr_i = 1'b0;
`endif
    tick();

    // 2: port 2 read of 0x0_0040
    set_port(2, 1'b1, 20'h0_0040, 4'hF, 32'h0);
    exp_gnt.push_back('{port: 2, addr: 32'h1C00_0040, wen: 1'b1, be: 4'hF, wdata: 32'h0});
    want_rsp(2, 32'hCAFE_F00D);
    s_req_i = 4'b0100; m_gnt_i = 1'b1;
    tick();
    s_req_i = 4'b0000; m_gnt_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    chk("t2_rvalid_vec", 64'(s_rvalid_o), 64'b0100);
    tick();
    m_rvalid_i = 1'b0;
    tick();

    // 3: no responses -> four grants fill the ID FIFO; no grant in the pop cycle
    want_gnt(3); want_gnt(0); want_gnt(1); want_gnt(2); want_gnt(3);
    want_rsp(3, 32'h3000_0006);
    for (int p = 0; p < 4; p++) want_rsp(p, 32'h3000_0008 + 32'(p));
    for (int c = 0; c < 12; c++) begin
      s_req_i    = (c <= 7) ? 4'hF : 4'h0;
      m_gnt_i    = 1'b1;
      m_rvalid_i = (c == 6) || (c >= 8);
      m_rdata_i  = 32'h3000_0000 + 32'(c);
      if (c >= 4 && c <= 6) begin
        @(negedge clk_i);
        chk("t3_full_req", 64'(m_req_o), 64'd0);
        chk("t3_full_gnt", 64'(s_gnt_o), 64'd0);
      end
      tick();
    end
    m_rvalid_i = 1'b0; m_gnt_i = 1'b0;
    tick();

    // 4: ports 1,3 request without grant; pointer must hold
    s_req_i = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("t4_hold_gnt",  64'(s_gnt_o),  64'd0);
      chk("t4_hold_req",  64'(m_req_o),  64'd1);
      chk("t4_hold_addr", 64'(m_addr_o), 64'h1C00_1010);
      tick();
    end
    want_gnt(1); want_gnt(3);
    want_rsp(1, 32'h4000_0004); want_rsp(3, 32'h4000_0005);
    m_gnt_i = 1'b1;
    tick();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h4000_0004;
    tick();
    s_req_i = 4'b0000; m_gnt_i = 1'b0; m_rdata_i = 32'h4000_0005;
    tick();
    m_rvalid_i = 1'b0;
    tick();

    // 5: response with empty FIFO sets sticky error
    @(negedge clk_i);
    chk("t5_err_before", 64'(err_o), 64'd0);
    tick();
    m_rvalid_i = 1'b1; m_rdata_i = 32'hDEAD_BEEF;
    tick();
    m_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("t5_err_set", 64'(err_o), 64'd1);
    repeat (3) tick();
    @(negedge clk_i);
    chk("t5_err_sticky", 64'(err_o), 64'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("t5_err_rst", 64'(err_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    // Reset with a transaction outstanding: its late response is an error
    want_gnt(0);
    s_req_i = 4'b0001; m_gnt_i = 1'b1;
    tick();
    s_req_i = 4'b0000; m_gnt_i = 1'b0;
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    chk("t5_mid_rst_err", 64'(err_o), 64'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h1234_5678;
    tick();
    m_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("t5_late_rsp_err", 64'(err_o), 64'd1);
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();

`ifdef EFPGA_TCDM_ARB_STATS_EN
    // 6: saturation and clear-wins-over-grant
    mon_en = 1'b0;
    for (int c = 0; c <= 70000; c++) begin
      s_req_i    = (c < 70000) ? 4'b0001 : 4'b0000;
      m_gnt_i    = 1'b1;
      m_rvalid_i = (c >= 1);
      tick();
    end
    s_req_i = '0; m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("t6_sat_p0", 64'(stat_cnt_o[15:0]),  64'hFFFF);
    chk("t6_sat_p1", 64'(stat_cnt_o[31:16]), 64'd0);
    tick();
    mon_en = 1'b1;
    want_gnt(0); want_gnt(0);
    want_rsp(0, 32'h6000_0001); want_rsp(0, 32'h6000_0002);
    s_req_i = 4'b0001; m_gnt_i = 1'b1; stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'h6000_0001;
    @(negedge clk_i);
    chk("t6_clr_wins", 64'(stat_cnt_o[15:0]), 64'd0);
    tick();
    s_req_i = 4'b0000; m_gnt_i = 1'b0; m_rdata_i = 32'h6000_0002;
    @(negedge clk_i);
    chk("t6_after_clr", 64'(stat_cnt_o[15:0]), 64'd1);
    tick();
    m_rvalid_i = 1'b0;
    tick();
`endif

    chk("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
